// File: rtl/openhmc_rf_master.sv
// Register-file access master: accepts one read/write request at a time, strobes the
// RF for a single cycle, waits for completion or timeout and holds the response until taken.
module openhmc_rf_master #(
  parameter int HMC_RF_AWIDTH  = 4,
  parameter int HMC_RF_RWIDTH  = 64,
  parameter int HMC_RF_WWIDTH  = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk_hmc,
  input  logic                     res_hmc,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [HMC_RF_AWIDTH-1:0] req_addr,
  input  logic [HMC_RF_WWIDTH-1:0] req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [HMC_RF_RWIDTH-1:0] rsp_rdata,
  output logic [1:0]               rsp_status,
  output logic [HMC_RF_AWIDTH-1:0] rf_address,
  output logic                     rf_read_en,
  output logic                     rf_write_en,
  output logic [HMC_RF_WWIDTH-1:0] rf_write_data,
  input  logic [HMC_RF_RWIDTH-1:0] rf_read_data,
  input  logic                     rf_access_complete,
  input  logic                     rf_invalid_address,
  output logic                     stray_complete
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] STATUS_OK      = 2'b00;
  localparam logic [1:0] STATUS_INVALID = 2'b01;
  localparam logic [1:0] STATUS_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t                   state_q, state_d;
  logic                     write_q, write_d;
  logic [HMC_RF_AWIDTH-1:0] addr_q, addr_d;
  logic [HMC_RF_WWIDTH-1:0] wdata_q, wdata_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [HMC_RF_RWIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]               status_q, status_d;
  logic                     stray_q, stray_d;

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    status_d = status_q;
    stray_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        stray_d = rf_access_complete;
        if (req_valid) begin
          state_d = ST_ISSUE;
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_write ? req_wdata : '0;
          cnt_d   = '0;
        end
      end
      ST_ISSUE, ST_WAIT: begin
        // A completion always beats the timeout, even on the last allowed wait cycle.
        if (rf_access_complete) begin
          state_d  = ST_RESP;
          status_d = rf_invalid_address ? STATUS_INVALID : STATUS_OK;
          rdata_d  = (!write_q && !rf_invalid_address) ? rf_read_data : '0;
        end else if (state_q == ST_ISSUE) begin
          state_d = ST_WAIT;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_d  = ST_RESP;
            status_d = STATUS_TIMEOUT;
            rdata_d  = '0;
          end
        end
      end
      ST_RESP: begin
        stray_d = rf_access_complete;
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_hmc) begin
    if (res_hmc) begin
      state_q  <= ST_IDLE;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      status_q <= STATUS_OK;
      stray_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      status_q <= status_d;
      stray_q  <= stray_d;
    end
  end

  assign req_ready      = (state_q == ST_IDLE);
  assign rsp_valid      = (state_q == ST_RESP);
  assign rsp_rdata      = rdata_q;
  assign rsp_status     = status_q;
  assign rf_address     = addr_q;
  assign rf_write_data  = wdata_q;
  assign rf_read_en     = (state_q == ST_ISSUE) && !write_q;
  assign rf_write_en    = (state_q == ST_ISSUE) && write_q;
  assign stray_complete = stray_q;

endmodule

// File: tb/tb_openhmc_rf_master.sv
// Randomized transaction-level bench for openhmc_rf_master; expected timing and
// response contents come from a per-transaction arithmetic model.
module tb_openhmc_rf_master;

  localparam int AW = 4;
  localparam int RW = 64;
  localparam int WW = 64;
  localparam int T  = 8;

  logic          clk_hmc = 1'b0;
  logic          res_hmc;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [WW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [RW-1:0] rsp_rdata;
  logic [1:0]    rsp_status;
  logic [AW-1:0] rf_address;
  logic          rf_read_en, rf_write_en;
  logic [WW-1:0] rf_write_data;
  logic [RW-1:0] rf_read_data;
  logic          rf_access_complete, rf_invalid_address;
  logic          stray_complete;

  int n_cmp = 0;
  int n_err = 0;
  logic stray_next = 1'b0;

  openhmc_rf_master #(
    .HMC_RF_AWIDTH (AW),
    .HMC_RF_RWIDTH (RW),
    .HMC_RF_WWIDTH (WW),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk_hmc           (clk_hmc),
    .res_hmc           (res_hmc),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_write         (req_write),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_rdata         (rsp_rdata),
    .rsp_status        (rsp_status),
    .rf_address        (rf_address),
    .rf_read_en        (rf_read_en),
    .rf_write_en       (rf_write_en),
    .rf_write_data     (rf_write_data),
    .rf_read_data      (rf_read_data),
    .rf_access_complete(rf_access_complete),
    .rf_invalid_address(rf_invalid_address),
    .stray_complete    (stray_complete)
  );

  always #5 clk_hmc = ~clk_hmc;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one cycle; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk_hmc);
    #1;
    check_eq("stray_complete", stray_complete, stray_next);
    stray_next         = 1'b0;
    rf_access_complete = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req_ready"}, req_ready, 1'b1);
    check_eq({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    check_eq({tag, "_rsp_rdata"}, rsp_rdata, 64'h0);
    check_eq({tag, "_rsp_status"}, rsp_status, 2'b00);
    check_eq({tag, "_strobes"}, {rf_read_en, rf_write_en}, 2'b00);
    check_eq({tag, "_rf_address"}, rf_address, 64'h0);
    check_eq({tag, "_rf_wdata"}, rf_write_data, 64'h0);
  endtask

  // d = completion offset from the ISSUE cycle (0 = in ISSUE); d > T means none arrives.
  task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input logic [WW-1:0] wd,
                         input int d, input bit inv, input logic [RW-1:0] rd, input int hold);
    int            exp_rel, got_rel, rd_cnt, wr_cnt;
    logic [1:0]    exp_status;
    logic [RW-1:0] exp_rdata;
    logic [WW-1:0] exp_wdata;
    bit            timed_out;

    timed_out  = (d > T);
    exp_rel    = timed_out ? T + 1 : d + 1;
    exp_status = timed_out ? 2'b10 : (inv ? 2'b01 : 2'b00);
    exp_rdata  = (!timed_out && !wr && !inv) ? rd : '0;
    exp_wdata  = wr ? wd : '0;

    check_eq("idle_req_ready", req_ready, 1'b1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    step();
    req_valid = 1'b0;
    req_addr  = AW'($urandom);
    req_wdata = {$urandom, $urandom};

    got_rel = -1;
    rd_cnt  = 0;
    wr_cnt  = 0;
    for (int rel = 0; rel <= T + 3; rel++) begin
      if (rsp_valid) begin
        got_rel = rel;
        break;
      end
      rd_cnt += int'(rf_read_en);
      wr_cnt += int'(rf_write_en);
      check_eq("busy_req_ready", req_ready, 1'b0);
      check_eq("busy_rf_address", rf_address, addr);
      check_eq("busy_rf_wdata", rf_write_data, exp_wdata);
      rf_invalid_address = inv;
      rf_read_data       = rd;
      if (rel == d) begin
        rf_access_complete = 1'b1;
      end else begin
        rf_invalid_address = 1'($urandom);
        rf_read_data       = {$urandom, $urandom};
      end
      step();
    end
    check_eq("resp_latency", 64'(got_rel), 64'(exp_rel));
    check_eq("read_strobes", 64'(rd_cnt), 64'(!wr));
    check_eq("write_strobes", 64'(wr_cnt), 64'(wr));

    for (int i = 0; i <= hold; i++) begin
      check_eq("resp_valid", rsp_valid, 1'b1);
      check_eq("resp_status", rsp_status, exp_status);
      check_eq("resp_rdata", rsp_rdata, exp_rdata);
      check_eq("resp_req_ready", req_ready, 1'b0);
      check_eq("resp_strobes", {rf_read_en, rf_write_en}, 2'b00);
      check_eq("resp_rf_address", rf_address, addr);
      check_eq("resp_rf_wdata", rf_write_data, exp_wdata);
      if (i == 0 && timed_out) begin
        rf_access_complete = 1'b1;
        stray_next         = 1'b1;
      end
      rsp_ready = (i == hold);
      req_valid = (i < hold) ? 1'($urandom) : 1'b0;
      req_write = 1'($urandom);
      step();
    end
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check_eq("after_rsp_valid", rsp_valid, 1'b0);
    check_eq("after_req_ready", req_ready, 1'b1);
    $display("txn wr=%0d addr=0x%0h d=%0d inv=%0d hold=%0d status=%0d rdata=0x%0h",
             wr, addr, d, inv, hold, exp_status, exp_rdata);
  endtask

  initial begin
    res_hmc = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    rf_read_data = '0;
    rf_access_complete = 1'b0;
    rf_invalid_address = 1'b0;

    step();
    step();
    res_hmc = 1'b0;
    step();
    check_reset_outputs("reset");

    run_txn(1'b0, 4'h3, 64'h0, 2, 1'b0, 64'h0123_4567_89AB_CDEF, 0);
    run_txn(1'b1, 4'h5, 64'hDEAD_BEEF, 0, 1'b0, 64'h5555_AAAA_5555_AAAA, 0);
    run_txn(1'b0, 4'hF, 64'h0, 1, 1'b1, 64'h1234_5678_9ABC_DEF0, 1);
    run_txn(1'b0, 4'h7, 64'h0, T + 1, 1'b0, 64'hFFFF_0000_FFFF_0000, 0);
    run_txn(1'b0, 4'h9, 64'h0, T, 1'b0, 64'hCAFE_F00D_CAFE_F00D, 0);
    run_txn(1'b1, 4'hA, 64'h1111_2222_3333_4444, 3, 1'b0, 64'h99, 5);

    // Completion while idle must only produce a stray pulse.
    rf_access_complete = 1'b1;
    stray_next = 1'b1;
    step();
    check_eq("idle_stray_stays_idle", req_ready, 1'b1);

    for (int n = 0; n < 40; n++) begin
      run_txn(1'($urandom), AW'($urandom), {$urandom, $urandom},
              int'($urandom_range(0, T + 2)), ($urandom_range(0, 3) == 0),
              {$urandom, $urandom}, int'($urandom_range(0, 5)));
      if ($urandom_range(0, 3) == 0) begin
        rf_access_complete = 1'b1;
        stray_next = 1'b1;
        step();
      end
    end

    // Reset during WAIT abandons the access; its late completion is only a stray pulse.
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 4'h6;
    step();
    req_valid = 1'b0;
    step();
    step();
    check_eq("midreset_in_wait", rf_address, 4'h6);
    res_hmc = 1'b1;
    step();
    res_hmc = 1'b0;
    check_reset_outputs("midreset");
    step();
    check_reset_outputs("midreset_hold");
    rf_access_complete = 1'b1;
    rf_read_data = 64'hBAD0_BAD0_BAD0_BAD0;
    stray_next = 1'b1;
    step();
    check_reset_outputs("late_complete");
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("late_no_rsp", rsp_valid, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
